// File: rtl/mult4_stall_unit.sv
// Iterative low-half multiplier for MUL in EX; freezes the front of the pipeline while it works.
// Latency: STEPS+1 cycles from start (IDLE) to result_valid (DONE), one SLICE of operand_b per BUSY cycle.
// Backpressure: drives stall_pipeline (combinational in IDLE) until DONE; flush_ex aborts and drops the stall at once.
module mult4_stall_unit #(
    parameter int WIDTH = 32,
    parameter int STEPS = 4
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             mul_start_ex,
    input  logic             flush_ex,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             stall_pipeline,
    output logic             mul_busy
);

    localparam int SLICE = WIDTH / STEPS;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int SH_W  = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   count;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;

    logic [SH_W-1:0]    shamt;
    logic [SLICE-1:0]   slice_bits;
    logic [WIDTH-1:0]   partial;
    logic [WIDTH-1:0]   acc_nxt;
    logic               last_step;
    logic               start_ok;

    // Partial product of a_q with the current slice of b_q, weighted by the slice position.
    always_comb begin
        shamt      = SH_W'(count) * SH_W'(SLICE);
        slice_bits = SLICE'(b_q >> shamt);
        partial    = a_q * WIDTH'(slice_bits);
        acc_nxt    = acc + (partial << shamt);
        last_step  = (count == CNT_W'(STEPS - 1));
        start_ok   = mul_start_ex && !flush_ex;
    end

    always_comb begin
        state_nxt      = state;
        stall_pipeline = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_nxt      = BUSY;
                    stall_pipeline = 1'b1;
                end
            end
            BUSY: begin
                if (flush_ex) begin
                    state_nxt = IDLE;
                end else begin
                    stall_pipeline = 1'b1;
                    if (last_step) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                // mul_start_ex still reflects the MUL just finished, so it is ignored here.
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign result_valid = (state == DONE);
    assign mul_busy     = (state == BUSY);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state  <= IDLE;
            count  <= '0;
            acc    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            result <= '0;
        end else begin
            state <= state_nxt;
            if (flush_ex) begin
                count <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (mul_start_ex) begin
                            a_q   <= operand_a;
                            b_q   <= operand_b;
                            acc   <= '0;
                            count <= '0;
                        end
                    end
                    BUSY: begin
                        acc   <= acc_nxt;
                        count <= count + CNT_W'(1);
                        if (last_step) begin
                            result <= acc_nxt;
                        end
                    end
                    default: begin
                        count <= '0;
                    end
                endcase
            end
        end
    end

endmodule
